muladd_rr_arbiter: RTL and testbench
====================================

# muladd_rr_arbiter

Round-robin arbiter that shares one pipelined unsigned multiply-add datapath (p = a*b ± c, 26×17 + 48 bit, DSP48E2-mapped) between NREQ independent requesters. It accepts at most one operation per cycle through per-requester valid/ready handshakes, tags each operation with its requester index, and returns the tagged result LAT cycles later. A drain state machine quiesces the shared unit for reconfiguration or clock gating upstream.

## Interface
- NREQ, 4, number of requesters (2..8)
- LAT, 3, datapath pipeline depth in registers (1..4)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester grant; one-hot or zero
- req_a  in  NREQ*26  packed multiplicand, requester i at [26*i +: 26]
- req_b  in  NREQ*17  packed multiplier, requester i at [17*i +: 17]
- req_c  in  NREQ*48  packed addend, requester i at [48*i +: 48]
- req_sub  in  NREQ  1 = subtract c, 0 = add c
- res_valid  out  1  result valid, single-cycle pulse per operation
- res_id  out  clog2(NREQ)  requester index of result
- res_data  out  48  result
- drain  in  1  level request to stop issuing
- drain_done  out  1  high while drained and pipeline empty
- busy  out  1  high while any operation is in flight

## Operation
- Arbitration: pointer ptr holds last granted index. Candidate order ptr+1, ptr+2, …, ptr (mod NREQ); first requester with req_valid high is granted. req_ready is combinational from req_valid, ptr and state; at most one bit high.
- Transfer occurs at an edge where req_valid[i] & req_ready[i]; ptr ← i on that edge. No transfer ⇒ ptr unchanged.
- Requester must hold valid and operands stable until transfer; ready may drop without transfer if another requester wins.
- Arithmetic: product = a*b, 43-bit unsigned, zero-extended to 48; res_data = product + c or product − c, modulo 2^48. No saturation, no flags.
- Tag (id, valid) travels in a LAT-deep shift register alongside the datapath; no bubble collapsing, no stalls, no result backpressure — consumer must accept every res_valid pulse.
- State machine, states RUN, DRAINING, DRAINED:
  - RUN: grants allowed. drain=1 → DRAINING (no grant in the cycle drain is first sampled high).
  - DRAINING: req_ready all zero; in-flight operations complete. Pipeline empty → DRAINED. drain=0 → RUN.
  - DRAINED: drain_done=1, req_ready zero. drain=0 → RUN; grants resume the following cycle.
- busy = OR of tag-pipeline valid bits.
- Reset (any time): ptr ← NREQ−1 (requester 0 wins first), state RUN, tag pipeline cleared, in-flight operations discarded with no result pulse. Reset values: req_ready 0, res_valid 0, res_id 0, res_data 0, drain_done 0, busy 0.

## Timing
- Operands registered on the transfer edge E; res_valid/res_id/res_data valid in the cycle following edge E+LAT−1 (LAT=1 ⇒ cycle directly after E).
- Throughput one operation per cycle; results ordered identically to transfers.
- drain sampled at clock edge; DRAINING→DRAINED on the edge after the final res_valid cycle begins, so drain_done rises one cycle after last result; with nothing in flight, DRAINED is reached two edges after drain rises.
- Simultaneous drain rise and req_valid: no transfer.
- req_ready depends combinationally on req_valid; no combinational path from any input to res_*.

## Configuration
- MULADD_ARB_SUB_EN defined: req_sub honoured, tagged per operation through the pipeline, datapath selects add/subtract.
- Undefined: req_sub ignored, no sub tag bit, datapath always adds (p = a*b + c).

## Test plan
- Requester 0 alone, a=3, b=5, c=7, sub=0, LAT=3 → req_ready[0] same cycle, res_valid one pulse after edge E+2, res_id=0, res_data=22.
- All four req_valid held high for 8 cycles → grants 0,1,2,3,0,1,2,3, one per cycle, req_ready one-hot; results return in same id order.
- a=2, b=3, c=10, sub=1 → with MULADD_ARB_SUB_EN res_data=48'hFFFF_FFFF_FFFC; without → 16.
- a=2^26−1, b=2^17−1, c=2^48−1, add → res_data=48'h07FF_FBFE_0000 (modulo wrap).
- Three transfers in flight, then drain=1 with all req_valid high → req_ready zero, three results delivered, drain_done rises one cycle after last, busy 0; drain=0 → grant resumes at requester after last granted.
- rst asserted with two operations in flight → outputs zero immediately, no res_valid for dropped operations; after release requester 0 granted first.

Source files
------------

// File: rtl/muladd_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned multiply-add unit (a*b +/- c) between NREQ requesters.
// Define MULADD_ARB_SUB_EN to honour req_sub; otherwise the unit always adds.
module muladd_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*26-1:0]      req_a,
  input  logic [NREQ*17-1:0]      req_b,
  input  logic [NREQ*48-1:0]      req_c,
  input  logic [NREQ-1:0]         req_sub,
  output logic                    res_valid,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic [47:0]             res_data,
  input  logic                    drain,
  output logic                    drain_done,
  output logic                    busy
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {RUN, DRAINING, DRAINED} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] cand;
  logic           fire;
  logic           empty_nxt;
  logic [LAT-1:0] vld_p;
  logic [IDW-1:0] id_p [LAT];

  logic [25:0]    a_p0;
  logic [16:0]    b_p0;
  logic [47:0]    c_p0;
  logic           sub_p0;
  logic [47:0]    sum_p0;
  logic [47:0]    res_raw;

  function automatic logic [47:0] muladd(input logic [25:0] a, input logic [16:0] b,
                                         input logic [47:0] c, input logic sub);
    logic [42:0] prod;
    prod = 43'(a) * 43'(b);
    return sub ? ({5'd0, prod} - c) : ({5'd0, prod} + c);
  endfunction

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    cand      = '0;
    fire      = 1'b0;
    if (!rst && state == RUN && !drain) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IDW'((int'(ptr) + k) % NREQ);
        if (!fire && req_valid[cand]) begin
          fire   = 1'b1;
          gnt_id = cand;
        end
      end
      req_ready[gnt_id] = fire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= IDW'(NREQ - 1);
      state <= RUN;
    end else begin
      state <= state_nxt;
      if (fire) ptr <= gnt_id;
    end
  end

  // Only the final result stage may be occupied when leaving DRAINING.
  always_comb begin
    empty_nxt = 1'b1;
    for (int i = 0; i < LAT - 1; i++)
      if (vld_p[i]) empty_nxt = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (drain) state_nxt = DRAINING;
      DRAINING: if (!drain) state_nxt = RUN;
                else if (empty_nxt) state_nxt = DRAINED;
      DRAINED:  if (!drain) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Stage p0: operands of the granted requester captured on the transfer edge
  always_ff @(posedge clk) begin
    if (fire) begin
      a_p0 <= req_a[int'(gnt_id)*26 +: 26];
      b_p0 <= req_b[int'(gnt_id)*17 +: 17];
      c_p0 <= req_c[int'(gnt_id)*48 +: 48];
    end
  end

`ifdef MULADD_ARB_SUB_EN
  always_ff @(posedge clk) begin
    if (fire) sub_p0 <= req_sub[gnt_id];
  end
`else
  logic unused_sub;
  assign unused_sub = ^req_sub;
  assign sub_p0     = 1'b0;
`endif

  assign sum_p0 = muladd(a_p0, b_p0, c_p0, sub_p0);

  // Stages p1..: result delay line matching the tag pipeline depth
  generate
    if (LAT == 1) begin : g_lat1
      assign res_raw = sum_p0;
    end else begin : g_latn
      logic [47:0] sum_pn [LAT-1];
      always_ff @(posedge clk) begin
        sum_pn[0] <= sum_p0;
        for (int i = 1; i < LAT - 1; i++) sum_pn[i] <= sum_pn[i-1];
      end
      assign res_raw = sum_pn[LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < LAT; i++) id_p[i] <= '0;
    end else begin
      vld_p[0] <= fire;
      id_p[0]  <= gnt_id;
      for (int i = 1; i < LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        id_p[i]  <= id_p[i-1];
      end
    end
  end

  // Data stages carry no reset, so the outputs are qualified by the tag valid.
  assign res_valid  = vld_p[LAT-1];
  assign res_id     = res_valid ? id_p[LAT-1] : '0;
  assign res_data   = res_valid ? res_raw : '0;
  assign busy       = |vld_p;
  assign drain_done = (state == DRAINED);

endmodule

// File: tb/tb_muladd_rr_arbiter.sv
// Randomized self-checking bench for muladd_rr_arbiter against a transaction-level reference model.
module tb_muladd_rr_arbiter;
  localparam int N  = 4;
  localparam int L  = 3;
  localparam int IW = $clog2(N);

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*26-1:0] req_a;
  logic [N*17-1:0] req_b;
  logic [N*48-1:0] req_c;
  logic [N-1:0]    req_sub;
  logic            res_valid;
  logic [IW-1:0]   res_id;
  logic [47:0]     res_data;
  logic            drain;
  logic            drain_done;
  logic            busy;

  muladd_rr_arbiter #(.NREQ(N), .LAT(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_sub(req_sub),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .drain(drain), .drain_done(drain_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          id;
    logic [47:0] data;
  } exp_t;

  exp_t        q[$];
  logic [25:0] op_a [N];
  logic [16:0] op_b [N];
  logic [47:0] op_c [N];
  logic        op_s [N];
  int          m_ptr, m_state, cyc;
  int          obs_gnt, last_gid, last_id;
  logic [47:0] last_data;
  int          n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [47:0] ref_muladd(input logic [25:0] a, input logic [16:0] b,
                                             input logic [47:0] c, input logic s);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
`ifdef MULADD_ARB_SUB_EN
    if (s) return 48'(p - 64'(c));
`endif
    return 48'(p + 64'(c));
  endfunction

  task automatic set_op(input int i, input logic [25:0] a, input logic [16:0] b,
                        input logic [47:0] c, input logic s);
    op_a[i] = a; op_b[i] = b; op_c[i] = c; op_s[i] = s;
    req_a[26*i +: 26] = a;
    req_b[17*i +: 17] = b;
    req_c[48*i +: 48] = c;
    req_sub[i]        = s;
  endtask

  task automatic new_op(input int i);
    if ($urandom_range(7) == 0)
      set_op(i, '1, '1, '1, 1'($urandom));
    else
      set_op(i, 26'($urandom), 17'($urandom), 48'({$urandom, $urandom}), 1'($urandom));
  endtask

  // One clock cycle: compare against the model at the falling edge, then advance the model.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int           gid, idx;
    @(negedge clk);
    exp_rdy = '0;
    gid     = -1;
    if (m_state == 0 && !drain)
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (gid < 0 && req_valid[idx]) gid = idx;
      end
    if (gid >= 0) exp_rdy[gid] = 1'b1;
    obs_gnt = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) obs_gnt = i;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'(q.size() != 0));
    chk("drain_done", 64'(drain_done), 64'(m_state == 2));
    if (q.size() != 0 && q[0].due == cyc) begin
      chk("res_valid", 64'(res_valid), 64'd1);
      chk("res_id", 64'(res_id), 64'(q[0].id));
      chk("res_data", 64'(res_data), 64'(q[0].data));
      last_data = res_data;
      last_id   = int'(res_id);
      void'(q.pop_front());
    end else begin
      chk("res_valid_idle", 64'(res_valid), 64'd0);
    end
    last_gid = gid;
    if (gid >= 0) begin
      q.push_back('{due: cyc + L, id: gid, data: ref_muladd(op_a[gid], op_b[gid], op_c[gid], op_s[gid])});
      m_ptr = gid;
    end
    case (m_state)
      0: if (drain) m_state = 1;
      1: if (!drain) m_state = 0; else if (q.size() == 0) m_state = 2;
      2: if (!drain) m_state = 0;
      default: m_state = 0;
    endcase
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    req_valid = '0;
    repeat (L + 2) step();
  endtask

  task automatic single(input int i, input logic [25:0] a, input logic [16:0] b,
                        input logic [47:0] c, input logic s);
    set_op(i, a, b, c, s);
    req_valid[i] = 1'b1;
    step();
    chk("single_gnt", 64'(obs_gnt), 64'(i));
    req_valid[i] = 1'b0;
    repeat (L) step();
    chk("single_id", 64'(last_id), 64'(i));
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr   = N - 1;
    m_state = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_gnt;
    n_chk = 0; n_fail = 0; cyc = 0;
    last_data = '0; last_id = -1; last_gid = -1; obs_gnt = -1;
    rst = 1'b1; drain = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_c = '0; req_sub = '0;
    for (int i = 0; i < N; i++) set_op(i, '0, '0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_drain_done", 64'(drain_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // all requesters contending: strict rotation from requester 0
    for (int i = 0; i < N; i++) new_op(i);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_order", 64'(obs_gnt), 64'(k % N));
      if (last_gid >= 0) new_op(last_gid);
    end
    flush();

    single(0, 26'd3, 17'd5, 48'd7, 1'b0);
    chk("basic_22", 64'(last_data), 64'd22);
    single(1, 26'd2, 17'd3, 48'd10, 1'b1);
`ifdef MULADD_ARB_SUB_EN
    chk("sub_wrap", 64'(last_data), 64'h0000_FFFF_FFFF_FFFC);
`else
    chk("sub_ignored", 64'(last_data), 64'd16);
`endif
    single(2, '1, '1, '1, 1'b0);
    chk("max_wrap", 64'(last_data), 64'h0000_07FF_FBFE_0000);

    // three in flight, then drain with everyone requesting
    for (int i = 0; i < N; i++) new_op(i);
    req_valid = '1;
    last_gnt  = -1;
    repeat (3) begin
      step();
      last_gnt = obs_gnt;
      if (last_gid >= 0) new_op(last_gid);
    end
    drain = 1'b1;
    for (int i = 0; i < 20 && !drain_done; i++) step();
    chk("drain_reached", 64'(drain_done), 64'd1);
    chk("drain_busy", 64'(busy), 64'd0);
    step();
    drain = 1'b0;
    step();
    step();
    chk("drain_resume", 64'(obs_gnt), 64'((last_gnt + 1) % N));
    if (last_gid >= 0) new_op(last_gid);

    // random traffic with occasional drain requests
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(29) == 0) drain = ~drain;
      step();
      for (int i = 0; i < N; i++)
        if (last_gid == i || !req_valid[i]) begin
          req_valid[i] = 1'($urandom);
          if (req_valid[i]) new_op(i);
        end
    end
    drain = 1'b0;
    flush();

    // reset with two operations in flight
    for (int i = 0; i < N; i++) new_op(i);
    req_valid = '1;
    repeat (2) begin
      step();
      if (last_gid >= 0) new_op(last_gid);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", 64'(req_ready), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_res_data", 64'(res_data), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("arst_first_gnt", 64'(obs_gnt), 64'd0);
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
